// File: rtl/dcim_shift_acc.sv
// dcim_shift_acc
//   Bit-serial shift-and-add accumulator fed by the macro adder tree. Each live
//   cycle delivers one signed partial sum for bit-plane `sel`. The block weights
//   it by 2^sel, optionally negates the MSB plane (two's-complement input), and
//   emits one full-precision MAC result per operation.
//
// Ports
//   clk      in   1       clock, all state updates on posedge
//   rstn     in   1       asynchronous active-low reset
//   sel      in   6       bit-plane index from gctrl
//   st       in   1       gctrl status: 1 = idle/done, 0 = busy (psum valid)
//   inwidth  in   1       0 = 12-bit operand (msb 11), 1 = 24-bit operand (msb 23)
//   psum     in   PSUM_W  signed partial sum for plane sel
//   result   out  ACC_W   signed MAC result, held until the next completion
//   out_vld  out  1       one-cycle pulse: result updated
//   seq_err  out  1       one-cycle pulse: plane sequence violated, op discarded
module dcim_shift_acc #(
  parameter int PSUM_W = 10,
  parameter int ACC_W  = 36,
  parameter int SIGNED = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [5:0]               sel,
  input  logic                     st,
  input  logic                     inwidth,
  input  logic signed [PSUM_W-1:0] psum,
  output logic signed [ACC_W-1:0]  result,
  output logic                     out_vld,
  output logic                     seq_err
);

  localparam logic [5:0] MSB_12 = 6'd11;
  localparam logic [5:0] MSB_24 = 6'd23;

  typedef enum logic {IDLE, ACC} state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [5:0]                exp_sel;
  logic [5:0]                msb_l;

  logic                      live;
  logic                      neg_plane;
  logic signed [ACC_W-1:0]   term;

  // Sign-extend the partial sum, weight it by 2^s and negate on the MSB plane.
  function automatic logic signed [ACC_W-1:0] weight_term(
    input logic signed [PSUM_W-1:0] p,
    input logic [5:0]               s,
    input logic                     neg
  );
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] shf;
    ext = {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    shf = ext <<< s;
    return neg ? -shf : shf;
  endfunction

  assign live = ~st;

  // Plane 0 can never be the MSB plane, so the negation only matters in ACC
  // where msb_l has already been latched for this operation.
  assign neg_plane = (SIGNED != 0) && (state == ACC) && (sel == msb_l);
  assign term      = weight_term(psum, sel, neg_plane);

  // ---- accumulate / complete stage ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      acc     <= '0;
      exp_sel <= '0;
      msb_l   <= MSB_12;
      result  <= '0;
      out_vld <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      seq_err <= 1'b0;
      case (state)
        IDLE: begin
          if (live) begin
            if (sel == 6'd0) begin
              acc     <= term;
              exp_sel <= 6'd1;
              msb_l   <= inwidth ? MSB_24 : MSB_12;
              state   <= ACC;
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        ACC: begin
          if (!live) begin
            // gctrl went idle before the MSB plane: drop silently.
            acc   <= '0;
            state <= IDLE;
          end else if (sel != exp_sel) begin
            // A stray sel==0 here is an error too; it does not restart.
            seq_err <= 1'b1;
            acc     <= '0;
            state   <= IDLE;
          end else if (sel == msb_l) begin
            result  <= acc + term;
            out_vld <= 1'b1;
            acc     <= '0;
            state   <= IDLE;
          end else begin
            acc     <= acc + term;
            exp_sel <= exp_sel + 6'd1;
          end
        end
        default: begin
          acc   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcim_shift_acc.sv
// Bench for dcim_shift_acc: directed bit-plane sequences, a plane-array model
// evaluated as a weighted sum on completion, and literal checks on key results.
module tb_dcim_shift_acc;

  localparam int PSUM_W = 10;
  localparam int ACC_W  = 36;

  logic                     clk;
  logic                     rstn;
  logic [5:0]               sel;
  logic                     st;
  logic                     inwidth;
  logic signed [PSUM_W-1:0] psum;
  logic signed [ACC_W-1:0]  result;
  logic                     out_vld;
  logic                     seq_err;

  int total = 0;
  int bad   = 0;

  dcim_shift_acc #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .SIGNED(1)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sel     (sel),
    .st      (st),
    .inwidth (inwidth),
    .psum    (psum),
    .result  (result),
    .out_vld (out_vld),
    .seq_err (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_busy = 0;
  int     m_next = 0;
  int     m_msb  = 11;
  longint m_planes [24];
  longint m_result = 0;
  bit     m_vld = 0;
  bit     m_err = 0;

  function automatic longint evaluate(input int msb);
    longint s = 0;
    for (int i = 0; i <= msb; i++) begin
      if (i == msb) s -= m_planes[i] * (longint'(1) << i);
      else          s += m_planes[i] * (longint'(1) << i);
    end
    return s;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_next = 0; m_result = 0; m_vld = 0; m_err = 0;
    end else begin
      m_vld = 0;
      m_err = 0;
      if (!st) begin
        if (!m_busy) begin
          if (sel == 0) begin
            m_busy = 1;
            m_msb  = inwidth ? 23 : 11;
            m_next = 1;
            m_planes[0] = longint'(psum);
          end else begin
            m_err = 1;
          end
        end else if (int'(sel) != m_next) begin
          m_err  = 1;
          m_busy = 0;
        end else begin
          m_planes[sel] = longint'(psum);
          if (int'(sel) == m_msb) begin
            m_result = evaluate(m_msb);
            m_vld    = 1;
            m_busy   = 0;
          end else begin
            m_next++;
          end
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_vld = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (rstn) begin
      chk("out_vld", longint'(out_vld), longint'(m_vld));
      chk("seq_err", longint'(seq_err), longint'(m_err));
      chk("result",  longint'(result),  m_result);
      if (out_vld) n_vld++;
      if (seq_err) n_err++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit s_st, input int s_sel, input int s_psum);
    st   = s_st;
    sel  = 6'(s_sel);
    psum = PSUM_W'(s_psum);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 0, 0);
  endtask

  task automatic run_const(input bit w, input int msb, input int val);
    inwidth = w;
    for (int i = 0; i <= msb; i++) cyc(1'b0, i, val);
  endtask

  int v0, e0;

  initial begin
    rstn = 1'b0; st = 1'b1; sel = '0; psum = '0; inwidth = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Test 1: reset state
    chk("rst_result", longint'(result), 0);
    chk("rst_out_vld", longint'(out_vld), 0);
    chk("rst_seq_err", longint'(seq_err), 0);
    rstn = 1'b1;
    idle(3);

    // Test 2: 12-bit signed, all ones -> -1
    v0 = n_vld; e0 = n_err;
    run_const(1'b0, 11, 1);
    idle(2);
    chk("t2_model", m_result, -1);
    chk("t2_result", longint'(result), -1);
    chk("t2_vld_cnt", n_vld - v0, 1);
    chk("t2_err_cnt", n_err - e0, 0);

    // Test 3: 24-bit, 3 on plane 0 and 5 on plane 23
    v0 = n_vld;
    inwidth = 1'b1;
    for (int i = 0; i <= 23; i++) cyc(1'b0, i, (i == 0) ? 3 : ((i == 23) ? 5 : 0));
    idle(2);
    chk("t3_model", m_result, -41943037);
    chk("t3_result", longint'(result), -41943037);
    chk("t3_vld_cnt", n_vld - v0, 1);

    // Test 4: skipped plane -> seq_err, result held
    v0 = n_vld; e0 = n_err;
    inwidth = 1'b0;
    cyc(1'b0, 0, 7); cyc(1'b0, 1, 7); cyc(1'b0, 3, 7);
    idle(2);
    chk("t4_err_cnt", n_err - e0, 1);
    chk("t4_vld_cnt", n_vld - v0, 0);
    chk("t4_result", longint'(result), -41943037);

    // Test 4b: sel 0 mid-op errors without restarting; next sel 1 errors too
    e0 = n_err;
    cyc(1'b0, 0, 1); cyc(1'b0, 1, 1); cyc(1'b0, 0, 1); cyc(1'b0, 1, 1);
    idle(2);
    chk("t4b_err_cnt", n_err - e0, 2);

    // Test 5: abort a 24-bit op, then 12-bit with inwidth toggled mid-op
    v0 = n_vld; e0 = n_err;
    inwidth = 1'b1;
    for (int i = 0; i <= 5; i++) cyc(1'b0, i, 7);
    idle(2);
    chk("t5_abort_vld", n_vld - v0, 0);
    chk("t5_abort_err", n_err - e0, 0);
    inwidth = 1'b0;
    for (int i = 0; i <= 11; i++) begin
      if (i == 6) inwidth = 1'b1;
      cyc(1'b0, i, -2);
    end
    idle(2);
    chk("t5_result", longint'(result), 2);
    chk("t5_vld_cnt", n_vld - v0, 1);

    // Back-to-back ops: a new sel 0 in the out_vld cycle
    v0 = n_vld;
    run_const(1'b0, 11, 1);
    run_const(1'b0, 11, -2);
    idle(2);
    chk("b2b_vld_cnt", n_vld - v0, 2);
    chk("b2b_result", longint'(result), 2);

    // Test 6: reset in the middle of a 24-bit run
    v0 = n_vld;
    inwidth = 1'b1;
    for (int i = 0; i <= 9; i++) cyc(1'b0, i, 9);
    sel = 6'd10;
    rstn = 1'b0;
    #1;
    chk("t6_rst_result", longint'(result), 0);
    chk("t6_rst_vld", longint'(out_vld), 0);
    @(posedge clk); #1;
    st = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);
    chk("t6_vld_after_rst", n_vld - v0, 0);
    chk("t6_result_after_rst", longint'(result), 0);
    run_const(1'b0, 11, 1);
    idle(2);
    chk("t6_result", longint'(result), -1);
    chk("t6_vld_cnt", n_vld - v0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
